// File: rtl/pipelined_ripple_adder_pkg.sv
// adder_pkg: mode encodings and stage-count helper shared by the pipelined ripple adder
package adder_pkg;
  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;
  function automatic int num_stages(int width, int chunk);
    return (width / chunk < 1) ? 1 : width / chunk;
  endfunction
endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// pipelined_ripple_adder_if: operand/result valid-ready stream; master = source+sink side, slave = adder side
interface pipelined_ripple_adder_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic             out_valid, out_ready, out_cout, out_ovf;
  modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  input in_ready, out_valid, out_sum, out_cout, out_ovf);
  modport slave (input in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                 output in_ready, out_valid, out_sum, out_cout, out_ovf);
endinterface

// File: rtl/pipelined_ripple_adder_rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple slice (a, b, cin -> sum, cout, c_msb_in = carry into slice MSB)
module rca_chunk #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: one CHUNK slice per stage, skewed operands shift down, sum slices shift in from the top; ports clk, rst_n (sync active-low), bus (slave stream)
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst_n,
  pipelined_ripple_adder_if.slave bus
);
  localparam int NS = num_stages(WIDTH, CHUNK);
  logic             adv, ovf_q, ovf_d;
  logic [NS-1:0]    v_q, v_d;
  logic [WIDTH-1:0] a_q [NS], b_q [NS], s_q [NS];
  logic [WIDTH-1:0] a_d [NS], b_d [NS], s_d [NS];
  logic [WIDTH-1:0] a_s [NS], b_s [NS], s_s [NS];
  logic             c_q [NS], c_d [NS], c_s [NS];
  logic [CHUNK-1:0] sum [NS];
  logic             co [NS], cm [NS];
  assign adv           = ~v_q[NS-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NS-1];
  assign bus.out_sum   = s_q[NS-1];
  assign bus.out_cout  = c_q[NS-1];
  assign bus.out_ovf   = ovf_q;
  // operands are stored pre-shifted so the live slice always sits at bit 0
  always_comb begin
    a_s[0] = bus.in_a;
    b_s[0] = bus.in_sub == ADD_MODE ? bus.in_b : ~bus.in_b;
    c_s[0] = bus.in_sub == SUB_MODE ? 1'b1 : bus.in_cin;
    s_s[0] = '0;
    v_d[0] = bus.in_valid;
    for (int k = 1; k < NS; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      c_s[k] = c_q[k-1];
      s_s[k] = s_q[k-1];
      v_d[k] = v_q[k-1];
    end
  end
  for (genvar k = 0; k < NS; k++) begin : g_st
    rca_chunk #(.CHUNK(CHUNK)) u_rca (
      .a       (a_s[k][CHUNK-1:0]),
      .b       (b_s[k][CHUNK-1:0]),
      .cin     (c_s[k]),
      .sum     (sum[k]),
      .cout    (co[k]),
      .c_msb_in(cm[k])
    );
  end
  // each new slice enters at the top; after NS stages slice 0 has reached bit 0
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      a_d[k] = a_s[k] >> CHUNK;
      b_d[k] = b_s[k] >> CHUNK;
      s_d[k] = (s_s[k] >> CHUNK) | (WIDTH'(sum[k]) << (WIDTH - CHUNK));
      c_d[k] = co[k];
    end
    ovf_d = cm[NS-1] ^ co[NS-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed and random checks of the 8/4 and 32/8 adder configurations against a plain-arithmetic model
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int acc8 = 0;
  int got8 = 0;
  logic [33:0] q8 [$];
  logic [33:0] q32 [$];
  pipelined_ripple_adder_if #(.WIDTH(8))  b8 ();
  pipelined_ripple_adder_if #(.WIDTH(32)) b32 ();
  pipelined_ripple_adder #(.WIDTH(8), .CHUNK(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  pipelined_ripple_adder #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  initial forever #5 clk = ~clk;
  function automatic logic [33:0] ref_model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    logic [63:0] m, bb, full;
    logic [31:0] s;
    logic co, ov;
    m    = (64'd1 << w) - 64'd1;
    bb   = sub ? (~{32'h0, b}) & m : {32'h0, b};
    full = {32'h0, a} + bb + (sub ? 64'd1 : {63'd0, cin});
    s    = full[31:0] & m[31:0];
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic dir8(string tag, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                      logic [7:0] es, logic ec, logic eo);
    b8.in_valid = 1'b1; b8.in_a = a; b8.in_b = b; b8.in_cin = cin; b8.in_sub = sub;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    chk({tag, "_early"}, b8.out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, b8.out_valid, 1);
    chk({tag, "_sum"}, b8.out_sum, es);
    chk({tag, "_cout"}, b8.out_cout, ec);
    chk({tag, "_ovf"}, b8.out_ovf, eo);
    @(posedge clk); #1;
  endtask
  task automatic tick8();
    logic stall;
    logic [9:0] held;
    logic [33:0] e;
    #1;
    if (b8.in_valid && b8.in_ready) begin
      q8.push_back(ref_model(8, b8.in_a, b8.in_b, b8.in_cin, b8.in_sub));
      acc8++;
    end
    if (b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) chk("bp_extra_beat", 1, 0);
      else begin
        e = q8.pop_front();
        chk("bp_result", {b8.out_ovf, b8.out_cout, 24'h0, b8.out_sum}, e);
        got8++;
      end
    end
    stall = b8.out_valid && !b8.out_ready;
    held  = {b8.out_ovf, b8.out_cout, b8.out_sum};
    @(posedge clk); #1;
    if (stall) chk("bp_hold", {b8.out_valid, b8.out_ovf, b8.out_cout, b8.out_sum}, {1'b1, held});
  endtask
  initial begin
    int first_acc, first_v, acc, got;
    logic [33:0] e;
    b8.in_valid = 1'b1; b8.in_a = '0; b8.in_b = '0; b8.in_cin = 1'b0; b8.in_sub = 1'b0; b8.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_cin = 1'b0; b32.in_sub = 1'b0; b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_valid", b8.out_valid, 0);
    chk("rst_sum", b8.out_sum, 0);
    chk("rst_cout", b8.out_cout, 0);
    chk("rst_ovf", b8.out_ovf, 0);
    chk("rst_valid32", b32.out_valid, 0);
    rst_n = 1'b1; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", b8.in_ready, 1);
    chk("rst_no_beat", b8.out_valid, 0);
    dir8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir8("add_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    dir8("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    dir8("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    acc8 = 0; got8 = 0; q8.delete();
    for (int i = 0; i < 100 && got8 < 6; i++) begin
      b8.out_ready = (i % 3 == 0);
      b8.in_valid  = (acc8 < 6);
      b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      b8.in_cin = 1'($urandom); b8.in_sub = 1'($urandom);
      tick8();
    end
    chk("bp_count", got8, 6);
    chk("bp_leftover", q8.size(), 0);
    b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      #1;
      chk("mid_accept", b8.in_ready, 1);
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; b8.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("mid_discard", b8.out_valid, 0);
      @(posedge clk); #1;
    end
    first_acc = -1; first_v = -1; acc = 0; got = 0;
    for (int c = 0; c < 1100 && got < 1000; c++) begin
      b32.in_valid = (acc < 1000);
      b32.in_a = $urandom; b32.in_b = $urandom;
      b32.in_cin = 1'($urandom); b32.in_sub = 1'($urandom);
      #1;
      if (b32.out_valid && first_v < 0) first_v = c;
      if (b32.in_valid && b32.in_ready) begin
        if (first_acc < 0) first_acc = c;
        q32.push_back(ref_model(32, b32.in_a, b32.in_b, b32.in_cin, b32.in_sub));
        acc++;
      end
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) chk("fr_extra_beat", 1, 0);
        else begin
          e = q32.pop_front();
          chk("fr_result", {b32.out_ovf, b32.out_cout, b32.out_sum}, e);
          got++;
        end
      end
      @(posedge clk); #1;
    end
    chk("fr_latency", 64'(first_v - first_acc), 4);
    chk("fr_count", got, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
